// File: rtl/sap1_loader_pkg.sv
// Shared definitions for the SAP-1 program loader: FSM states, RAM depth,
// and the SAP-1 opcodes used to build images.
package sap1_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RECV    = 3'd1,
    S_WRITE   = 3'd2,
    S_CHECK   = 3'd3,
    S_RELEASE = 3'd4,
    S_DONE    = 3'd5,
    S_ERROR   = 3'd6
  } state_t;

  localparam int RAM_DEPTH = 16;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

endpackage

// File: rtl/sap1_loader.sv
// Streams an image into the SAP-1 RAM, verifies its 8-bit checksum and then
// releases the core from clear. The core stays cleared while loading.
module sap1_loader
  import sap1_loader_pkg::*;
#(
  parameter int WORDS      = 16,
  parameter int CLR_CYCLES = 2
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       prog,
  output logic       write,
  output logic [3:0] a,
  output logic [7:0] d,
  output logic       cpu_clr,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int AW = $clog2(RAM_DEPTH);
  localparam int TW = (CLR_CYCLES < 2) ? 1 : $clog2(CLR_CYCLES + 1);
  localparam logic [AW-1:0] LAST  = AW'(WORDS - 1);
  localparam logic [TW-1:0] TLOAD = TW'(CLR_CYCLES);

  state_t          state, n_state;
  logic [AW-1:0]   cnt, n_cnt;
  logic [7:0]      sum, n_sum;
  logic [TW-1:0]   timer, n_timer;
  logic            n_in_ready, n_prog, n_write, n_cpu_clr, n_busy, n_done, n_error;
  logic [3:0]      n_a;
  logic [7:0]      n_d;
  logic            xfer;

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= S_IDLE;
      cnt      <= '0;
      sum      <= '0;
      timer    <= '0;
      in_ready <= 1'b0;
      prog     <= 1'b0;
      write    <= 1'b0;
      a        <= '0;
      d        <= '0;
      cpu_clr  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state    <= n_state;
      cnt      <= n_cnt;
      sum      <= n_sum;
      timer    <= n_timer;
      in_ready <= n_in_ready;
      prog     <= n_prog;
      write    <= n_write;
      a        <= n_a;
      d        <= n_d;
      cpu_clr  <= n_cpu_clr;
      busy     <= n_busy;
      done     <= n_done;
      error    <= n_error;
    end
  end

  // Every output is a register; this block computes its next value.
  always_comb begin
    n_state    = state;
    n_cnt      = cnt;
    n_sum      = sum;
    n_timer    = timer;
    n_in_ready = in_ready;
    n_prog     = prog;
    n_write    = 1'b0;
    n_a        = a;
    n_d        = d;
    n_cpu_clr  = cpu_clr;
    n_busy     = busy;
    n_done     = done;
    n_error    = error;
    xfer       = in_valid & in_ready;

    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          n_state    = S_RECV;
          n_prog     = 1'b1;
          n_cpu_clr  = 1'b1;
          n_busy     = 1'b1;
          n_done     = 1'b0;
          n_error    = 1'b0;
          n_cnt      = '0;
          n_sum      = '0;
          n_in_ready = 1'b1;
        end
      end
      S_RECV: begin
        if (xfer) begin
          n_d        = in_data;
          n_a        = 4'(cnt);
          n_sum      = sum + in_data;
          n_write    = 1'b1;
          n_in_ready = 1'b0;
          n_state    = S_WRITE;
        end
      end
      S_WRITE: begin
        n_in_ready = 1'b1;
        // The counter parks on the last address instead of wrapping.
        if (cnt == LAST) begin
          n_state = S_CHECK;
        end else begin
          n_cnt   = cnt + 1'b1;
          n_state = S_RECV;
        end
      end
      S_CHECK: begin
        if (xfer) begin
          n_in_ready = 1'b0;
          if (in_data == sum) begin
            n_state = S_RELEASE;
            n_timer = TLOAD;
            n_prog  = 1'b0;
          end else begin
            n_state = S_ERROR;
            n_busy  = 1'b0;
            n_error = 1'b1;
          end
        end
      end
      S_RELEASE: begin
        n_timer = timer - TW'(1);
        if (timer == TW'(1)) begin
          n_state   = S_DONE;
          n_cpu_clr = 1'b0;
          n_busy    = 1'b0;
          n_done    = 1'b1;
        end
      end
      default: n_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sap1_loader.sv
// Self-checking bench for sap1_loader: scoreboarded RAM writes plus a small
// SAP-1 interpreter that runs the written image once the core is released.
module tb_sap1_loader;
  import sap1_loader_pkg::*;

  localparam int WORDS      = 16;
  localparam int CLR_CYCLES = 2;

  logic       clk = 1'b0;
  logic       clr, start, in_valid;
  logic [7:0] in_data;
  logic       in_ready, prog, write, cpu_clr, busy, done, error;
  logic [3:0] a;
  logic [7:0] d;

  int         checks = 0;
  int         failures = 0;
  int         writes;
  logic [11:0] sb[$];
  logic [7:0] ram [16];
  logic [7:0] image [16];
  logic [7:0] core_out;

  sap1_loader #(.WORDS(WORDS), .CLR_CYCLES(CLR_CYCLES)) dut (
    .clk(clk), .clr(clr), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .prog(prog), .write(write), .a(a), .d(d),
    .cpu_clr(cpu_clr), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Control bits packed as {prog, write, cpu_clr, busy, done, error, in_ready}.
  function automatic logic [15:0] ctrl();
    return {9'b0, prog, write, cpu_clr, busy, done, error, in_ready};
  endfunction

  function automatic logic [7:0] imageSum();
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < WORDS; i++) s = s + image[i];
    return s;
  endfunction

  // Each write strobe is checked against the byte the bench handed over.
  always @(negedge clk) begin
    if (write === 1'b1) begin
      logic [15:0] exp;
      writes++;
      exp = (sb.size() > 0) ? {4'h0, sb.pop_front()} : 16'hFFFF;
      checkOutput("wr_addr_data", {4'h0, a, d}, exp);
      checkOutput("wr_in_ready", 16'(in_ready), 16'd0);
      checkOutput("wr_prog", 16'(prog), 16'd1);
      ram[a] = d;
    end
  end

  task automatic runCore();
    logic [7:0] acc;
    logic [3:0] op, arg;
    acc = 8'h00;
    for (int pc = 0; pc < 16; pc++) begin
      op  = ram[pc][7:4];
      arg = ram[pc][3:0];
      if (op == OP_HLT) break;
      case (op)
        OP_LDA: acc = ram[arg];
        OP_ADD: acc = acc + ram[arg];
        OP_SUB: acc = acc - ram[arg];
        OP_OUT: core_out = acc;
        default: ;
      endcase
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic [3:0] addr, input int max_gap, input bit push);
    int gap, t;
    bit ok;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    ok = 1'b0;
    t  = 0;
    while (!ok && t < 40) begin
      if (in_ready) begin
        if (push) sb.push_back({addr, b});
        ok = 1'b1;
      end
      @(negedge clk);
      t++;
    end
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    checkOutput("handshake", 16'(ok), 16'd1);
  endtask

  // Junk byte offered alongside start must not be taken on the entry edge.
  task automatic startLoad();
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    checkOutput("start_entry", ctrl(), 16'b1011001);
  endtask

  task automatic loadImage(input logic [7:0] csum, input int max_gap, input int clr_after, input int start_at);
    startLoad();
    for (int i = 0; i < WORDS; i++) begin
      if (i == clr_after) begin
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checkOutput("clr_ctrl", ctrl(), 16'd0);
        checkOutput("clr_addr", 16'(a), 16'd0);
        sb.delete();
        return;
      end
      if (i == start_at) begin
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("start_ignored", ctrl(), 16'b1011001);
      end
      applyStimulus(image[i], 4'(i), max_gap, 1'b1);
    end
    applyStimulus(csum, 4'h0, max_gap, 1'b0);
    checkOutput("sb_drained", 16'(sb.size()), 16'd0);
  endtask

  task automatic expectDone(input logic [7:0] exp_out);
    int cyc;
    cyc = 0;
    checkOutput("release_ctrl", ctrl(), 16'b0011000);
    while (done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("release_cycles", 16'(cyc), 16'(CLR_CYCLES));
    checkOutput("done_ctrl", ctrl(), 16'b0000100);
    runCore();
    checkOutput("core_out", 16'(core_out), 16'(exp_out));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    clr = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    core_out = 8'h00; writes = 0;
    for (int i = 0; i < 16; i++) ram[i] = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("reset_ctrl", ctrl(), 16'd0);
    checkOutput("reset_ad", {4'h0, a, d}, 16'd0);
    clr = 1'b0;
    @(negedge clk);
    checkOutput("idle_hold", ctrl(), 16'd0);

    $display("[TB] full load");
    image = '{8'h09, 8'h1A, 8'h2B, 8'hE0, 8'hF0, 8'h00, 8'h00, 8'h00,
              8'h00, 8'h10, 8'h14, 8'h18, 8'h00, 8'h00, 8'h00, 8'h00};
    writes = 0;
    loadImage(imageSum(), 0, -1, -1);
    expectDone(8'h0C);
    checkOutput("t1_writes", 16'(writes), 16'd16);

    $display("[TB] bad checksum then recovery");
    loadImage(imageSum() + 8'h01, 0, -1, -1);
    checkOutput("error_ctrl", ctrl(), 16'b1010010);
    repeat (3) @(negedge clk);
    checkOutput("error_hold", ctrl(), 16'b1010010);
    loadImage(imageSum(), 0, -1, -1);
    expectDone(8'h0C);

    $display("[TB] backpressure and gaps");
    for (int i = 0; i < 16; i++) ram[i] = 8'h00;
    writes = 0;
    loadImage(imageSum(), 5, -1, -1);
    expectDone(8'h0C);
    checkOutput("t3_writes", 16'(writes), 16'd16);

    $display("[TB] clear mid-load");
    loadImage(imageSum(), 0, 7, -1);
    loadImage(imageSum(), 0, -1, -1);
    expectDone(8'h0C);

    $display("[TB] start during receive");
    loadImage(imageSum(), 0, -1, 3);
    expectDone(8'h0C);

    $display("[TB] reload after done");
    image = '{8'h09, 8'h1A, 8'hE0, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h00, 8'h22, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    loadImage(imageSum(), 0, -1, -1);
    expectDone(8'h33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
